// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus register responder and its channel FSMs.
package bus_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond
    } chan_state_e;

    localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/responder_channel_fsm.sv
// Accept/wait/respond sequencer for one request channel; decode and storage live outside.
module responder_channel_fsm
    import bus_responder_pkg::*;
#(
    parameter int unsigned WaitCycles = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic request_i,
    output logic accept_o,
    output logic ready_o,
    output logic busy_o,
    output logic done_o
);

    chan_state_e               state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        ready_o  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (request_i) begin
                    accept_o = 1'b1;
                    cnt_d    = CntWidth'(WaitCycles);
                    state_d  = StWait;
                end
            end
            StWait: begin
                busy_o = 1'b1;
                // Leaving at zero means WaitCycles=0 still spends one cycle here.
                if (cnt_q == '0) begin
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRespond: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/bus_register_responder.sv
// Register file responder with independent read and write channels, address decode
// and per-register read-only protection.
module bus_register_responder
    import bus_responder_pkg::*;
#(
    parameter logic [31:0]           BASE_ADDRESS   = 32'h0000_0000,
    parameter int unsigned           REG_NUMBER     = 8,
    parameter int unsigned           WAIT_CYCLES    = 2,
    parameter logic [REG_NUMBER-1:0] READ_ONLY_MASK = '0,
    parameter logic [31:0]           RESET_VALUE    = '0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_request_i,
    input  logic [31:0] write_address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_strobe_i,
    output logic        write_ready_o,
    output logic        write_busy_o,
    output logic        write_done_o,
    output logic        write_error_o,
    input  logic        read_request_i,
    input  logic [31:0] read_address_i,
    output logic        read_ready_o,
    output logic        read_busy_o,
    output logic        read_done_o,
    output logic        read_error_o,
    output logic [31:0] read_data_o
);

    localparam int unsigned IdxW = (REG_NUMBER > 1) ? $clog2(REG_NUMBER) : 1;

    // Addresses below the base wrap to huge offsets and fall out of range.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'((addr - BASE_ADDRESS) >> 2);
    endfunction

    logic        wr_accept, wr_done, rd_accept, rd_done;
    logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] regs_q [REG_NUMBER];
    logic [31:0] regs_d [REG_NUMBER];

    responder_channel_fsm #(
        .WaitCycles (WAIT_CYCLES)
    ) u_write_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (write_request_i),
        .accept_o  (wr_accept),
        .ready_o   (write_ready_o),
        .busy_o    (write_busy_o),
        .done_o    (wr_done)
    );

    responder_channel_fsm #(
        .WaitCycles (WAIT_CYCLES)
    ) u_read_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (read_request_i),
        .accept_o  (rd_accept),
        .ready_o   (read_ready_o),
        .busy_o    (read_busy_o),
        .done_o    (rd_done)
    );

    logic [29:0]     wr_word, rd_word;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic            wr_err, rd_err;
    logic [31:0]     rd_value;

    always_comb begin
        wr_word = word_index(wr_addr_q);
        rd_word = word_index(rd_addr_q);
        wr_idx  = wr_word[IdxW-1:0];
        rd_idx  = rd_word[IdxW-1:0];
        rd_err  = (rd_addr_q[1:0] != 2'b00) || ({2'b00, rd_word} >= REG_NUMBER);
        wr_err  = (wr_addr_q[1:0] != 2'b00) || ({2'b00, wr_word} >= REG_NUMBER);
        if (!wr_err) begin
            wr_err = READ_ONLY_MASK[wr_idx];
        end
        rd_value = rd_err ? 32'h0 : regs_q[rd_idx];
    end

    always_comb begin
        wr_addr_d = wr_accept ? write_address_i : wr_addr_q;
        wr_data_d = wr_accept ? write_data_i    : wr_data_q;
        wr_strb_d = wr_accept ? write_strobe_i  : wr_strb_q;
        rd_addr_d = rd_accept ? read_address_i  : rd_addr_q;
        rd_data_d = rd_done   ? rd_value        : rd_data_q;
        regs_d    = regs_q;
        if (wr_done && !wr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_q[b]) begin
                    regs_d[wr_idx][8*b +: 8] = wr_data_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            regs_q    <= '{default: RESET_VALUE};
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            regs_q    <= regs_d;
        end
    end

    // Read value is taken from pre-commit storage, so a same-cycle write is not visible.
    assign write_done_o  = wr_done;
    assign write_error_o = wr_done && wr_err;
    assign read_done_o   = rd_done;
    assign read_error_o  = rd_done && rd_err;
    assign read_data_o   = rd_done ? rd_value : rd_data_q;

endmodule

// File: tb/tb_bus_register_responder.sv
// Randomised and directed bench for bus_register_responder against a timeline-based model.
module tb_bus_register_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          REG_N = 8;
    localparam int          WAITC = 2;
    localparam logic [7:0]  ROM   = 8'b0000_0001;
    localparam logic [31:0] RSTV  = 32'h0000_00A5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        write_request_i = 1'b0;
    logic [31:0] write_address_i = '0;
    logic [31:0] write_data_i = '0;
    logic [3:0]  write_strobe_i = '0;
    logic        write_ready_o, write_busy_o, write_done_o, write_error_o;
    logic        read_request_i = 1'b0;
    logic [31:0] read_address_i = '0;
    logic        read_ready_o, read_busy_o, read_done_o, read_error_o;
    logic [31:0] read_data_o;

    always #5 clk_i = ~clk_i;

    bus_register_responder #(
        .BASE_ADDRESS   (BASE),
        .REG_NUMBER     (REG_N),
        .WAIT_CYCLES    (WAITC),
        .READ_ONLY_MASK (ROM),
        .RESET_VALUE    (RSTV)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .write_request_i (write_request_i),
        .write_address_i (write_address_i),
        .write_data_i    (write_data_i),
        .write_strobe_i  (write_strobe_i),
        .write_ready_o   (write_ready_o),
        .write_busy_o    (write_busy_o),
        .write_done_o    (write_done_o),
        .write_error_o   (write_error_o),
        .read_request_i  (read_request_i),
        .read_address_i  (read_address_i),
        .read_ready_o    (read_ready_o),
        .read_busy_o     (read_busy_o),
        .read_done_o     (read_done_o),
        .read_error_o    (read_error_o),
        .read_data_o     (read_data_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [REG_N];
    bit          m_on = 0;
    bit          m_wp, m_rp;
    int          m_wdone, m_rdone;
    logic [31:0] m_wa, m_wd, m_ra, m_rdata;
    logic [3:0]  m_ws;
    int          cyc = 0;

    function automatic bit addr_bad(input logic [31:0] a, input bit is_write);
        logic [31:0] off;
        logic [7:0]  rom;
        rom = ROM;
        off = a - BASE;
        if (a % 4 != 0) return 1;
        if (off / 4 >= REG_N) return 1;
        if (is_write && rom[off / 4]) return 1;
        return 0;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_N; i++) m_regs[i] = RSTV;
            m_wp = 0; m_rp = 0; m_rdata = '0; m_on = 1;
        end else begin
            bit was_w, was_r;
            was_w = m_wp;
            was_r = m_rp;
            if (m_wp && m_wdone == cyc) begin
                if (!addr_bad(m_wa, 1)) begin
                    for (int b = 0; b < 4; b++)
                        if (m_ws[b]) m_regs[(m_wa - BASE) / 4][8*b +: 8] = m_wd[8*b +: 8];
                end
                m_wp = 0;
            end
            if (m_rp && m_rdone == cyc) m_rp = 0;
            if (!was_w && write_request_i) begin
                m_wp = 1; m_wdone = cyc + WAITC + 2;
                m_wa = write_address_i; m_wd = write_data_i; m_ws = write_strobe_i;
            end
            if (!was_r && read_request_i) begin
                m_rp = 1; m_rdone = cyc + WAITC + 2; m_ra = read_address_i;
            end
            if (m_rp && m_rdone == cyc + 1)
                m_rdata = addr_bad(m_ra, 0) ? 32'h0 : m_regs[(m_ra - BASE) / 4];
        end
        cyc = cyc + 1;
    end

    always @(negedge clk_i) begin
        if (m_on) begin
            bit wd, rd;
            wd = m_wp && cyc == m_wdone;
            rd = m_rp && cyc == m_rdone;
            chk("write_ready", write_ready_o, !m_wp);
            chk("write_busy",  write_busy_o,  m_wp && cyc < m_wdone);
            chk("write_done",  write_done_o,  wd);
            chk("write_error", write_error_o, wd && addr_bad(m_wa, 1));
            chk("read_ready",  read_ready_o,  !m_rp);
            chk("read_busy",   read_busy_o,   m_rp && cyc < m_rdone);
            chk("read_done",   read_done_o,   rd);
            chk("read_error",  read_error_o,  rd && addr_bad(m_ra, 0));
            chk("read_data",   read_data_o,   m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        write_request_i = 1'b1; write_address_i = a; write_data_i = d; write_strobe_i = s;
        tick();
        write_request_i = 1'b0;
    endtask

    task automatic rd_req(input logic [31:0] a);
        read_request_i = 1'b1; read_address_i = a;
        tick();
        read_request_i = 1'b0;
    endtask

    // Called one cycle after accept; returns cycles from accept to done.
    task automatic wait_wr(output int lat);
        lat = 1;
        while (!write_done_o && lat < 40) begin tick(); lat++; end
    endtask

    task automatic wait_rd(output int lat);
        lat = 1;
        while (!read_done_o && lat < 40) begin tick(); lat++; end
    endtask

    task automatic do_write(input string n, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_err);
        int lat;
        wr_req(a, d, s);
        wait_wr(lat);
        chk({n, "_lat"}, lat, WAITC + 2);
        chk({n, "_err"}, write_error_o, exp_err);
        tick();
    endtask

    task automatic do_read(input string n, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_err);
        int lat;
        rd_req(a);
        wait_rd(lat);
        chk({n, "_lat"}, lat, WAITC + 2);
        chk({n, "_err"}, read_error_o, exp_err);
        chk({n, "_data"}, read_data_o, exp_d);
        tick();
    endtask

    initial begin
        int lat, cnt;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_wready", write_ready_o, 1'b1);
        chk("rst_rready", read_ready_o, 1'b1);
        chk("rst_rdata", read_data_o, 32'h0);

        do_write("w_deadbeef", BASE + 8, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_read("r_deadbeef", BASE + 8, 32'hDEAD_BEEF, 1'b0);

        do_write("w_reg1", BASE + 4, 32'h1122_3344, 4'hF, 1'b0);
        do_write("w_reg1_strb", BASE + 4, 32'hAABB_CCDD, 4'b0101, 1'b0);
        do_read("r_reg1", BASE + 4, 32'h11BB_33DD, 1'b0);

        do_write("w_misalign", BASE + 2, 32'h5555_5555, 4'hF, 1'b1);
        do_read("r_range", BASE + 4 * REG_N, 32'h0, 1'b1);
        do_read("r_below", BASE - 4, 32'h0, 1'b1);
        do_write("w_strb0", BASE + 8, 32'h0123_4567, 4'h0, 1'b0);
        do_read("r_unchanged", BASE + 8, 32'hDEAD_BEEF, 1'b0);

        do_write("w_ro", BASE, 32'hFFFF_FFFF, 4'hF, 1'b1);
        do_read("r_ro", BASE, RSTV, 1'b0);

        // A second request during WAIT must be dropped.
        wr_req(BASE + 16, 32'h0000_0042, 4'hF);
        wr_req(BASE + 16, 32'h0000_0077, 4'hF);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (write_done_o) cnt++;
            tick();
        end
        chk("one_done", cnt, 1);
        do_read("r_not_queued", BASE + 16, 32'h0000_0042, 1'b0);

        // Same-cycle read and write to register 3.
        do_write("w_reg3_old", BASE + 12, 32'h5, 4'hF, 1'b0);
        write_request_i = 1'b1; write_address_i = BASE + 12;
        write_data_i = 32'h9; write_strobe_i = 4'hF;
        read_request_i = 1'b1; read_address_i = BASE + 12;
        tick();
        write_request_i = 1'b0; read_request_i = 1'b0;
        wait_rd(lat);
        chk("simul_wdone", write_done_o, 1'b1);
        chk("simul_rdata", read_data_o, 32'h5);
        tick();
        do_read("r_reg3_new", BASE + 12, 32'h9, 1'b0);

        // Reset one cycle after accept aborts the write.
        wr_req(BASE + 20, 32'h0000_1234, 4'hF);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_wready", write_ready_o, 1'b1);
        chk("abort_rready", read_ready_o, 1'b1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (write_done_o) cnt++;
            tick();
        end
        chk("abort_no_done", cnt, 0);
        do_read("r_abort", BASE + 20, RSTV, 1'b0);

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            write_request_i = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)       write_address_i = BASE + 4 * $urandom_range(0, REG_N - 1);
            else if (r == 7) write_address_i = BASE + 4 * $urandom_range(REG_N, 20);
            else if (r == 8) write_address_i = BASE + ($urandom_range(0, 31) | 1);
            else             write_address_i = BASE - 4 * $urandom_range(1, 3);
            write_data_i   = $urandom;
            write_strobe_i = 4'($urandom_range(0, 15));
            read_request_i = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 8)       read_address_i = BASE + 4 * $urandom_range(0, REG_N - 1);
            else if (r == 8) read_address_i = BASE + 4 * $urandom_range(REG_N, 20);
            else             read_address_i = BASE + 32'h2;
            tick();
        end
        write_request_i = 1'b0;
        read_request_i  = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_register_responder.md
BUS_REGISTER_RESPONDER -- requirements
Module: bus_register_responder

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000: byte address of register 0.
REQ-002 SHALL have parameter REG_NUMBER, default 8: number of 32-bit registers, 2..64.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: extra cycles between accept and done, 0..15.
REQ-004 SHALL have parameter READ_ONLY_MASK, default '0 (REG_NUMBER bits): bit i set = register i read-only.
REQ-005 SHALL have parameter RESET_VALUE, default '0: reset value loaded into every register.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk_i in 1 rising-edge clock; rst_i in 1 synchronous active-high reset.
REQ-007 Write request ports SHALL be: write_request_i in 1 request strobe; write_address_i in 32 byte address; write_data_i in 32 data; write_strobe_i in 4 byte enables.
REQ-008 Write response ports SHALL be: write_ready_o out 1 can accept; write_busy_o out 1 transaction in progress; write_done_o out 1 one-cycle completion pulse; write_error_o out 1 error, valid with done.
REQ-009 Read request ports SHALL be: read_request_i in 1 request strobe; read_address_i in 32 byte address.
REQ-010 Read response ports SHALL be: read_ready_o out 1; read_busy_o out 1; read_done_o out 1 pulse; read_error_o out 1; read_data_o out 32, valid with done.

Function
REQ-011 Each channel SHALL run an independent FSM, states IDLE, WAIT, RESPOND.
REQ-012 IDLE: ready=1, busy=0; request high in IDLE SHALL be accepted, latching address/data/strobe, and move to WAIT.
REQ-013 WAIT: ready=0, busy=1; cycle counter loaded with WAIT_CYCLES on accept, decremented each cycle; at 0 go to RESPOND (WAIT_CYCLES=0: one WAIT cycle).
REQ-014 RESPOND: done=1 for exactly one cycle, busy=0, ready=0; next state IDLE. Accept-to-done latency = WAIT_CYCLES+2 cycles.
REQ-015 Requests while not IDLE SHALL be ignored; no queuing.
REQ-016 Decode: offset = address - BASE_ADDRESS (32-bit modulo); index = offset[31:2].
REQ-017 Error SHALL be raised with done when address[1:0] != 0, offset < 0 as wrap beyond range, or index >= REG_NUMBER.
REQ-018 Write to a READ_ONLY_MASK register SHALL set error and not modify storage.
REQ-019 Write commit SHALL occur in the RESPOND cycle, only without error, updating only bytes with strobe bit set; strobe 4'b0000 SHALL complete without error and change nothing.
REQ-020 Read data SHALL be sampled from storage in the RESPOND cycle; read_data_o SHALL be 0 on error and hold its last value otherwise until next read done.
REQ-021 Read and write RESPOND in the same cycle on the same register: read SHALL return the pre-write value.
REQ-022 write_error_o/read_error_o SHALL be 0 whenever the corresponding done is 0.

Reset
REQ-023 rst_i high SHALL force both FSMs to IDLE, counters to 0, all registers to RESET_VALUE, ready_o=1 on both channels (from first cycle after reset), busy/done/error=0, read_data_o=0.
REQ-024 Reset mid-transaction SHALL abort it: no commit, no done pulse.

Structure
REQ-025 Shared package bus_responder_pkg SHALL hold the channel state enum (IDLE, WAIT, RESPOND) and the WAIT_CYCLES counter width constant (4).
REQ-026 The accept/wait/respond FSM plus counter SHALL be one sub-module, responder_channel_fsm, instantiated once per channel; decode and storage live in the top.

Verification
REQ-027 WAIT_CYCLES=2, write addr BASE+8, data 32'hDEAD_BEEF, strobe 4'hF -> done at accept+4, error 0; read BASE+8 -> read_data_o 32'hDEAD_BEEF.
REQ-028 Register 1 = 32'h1122_3344, write 32'hAABB_CCDD strobe 4'b0101 -> register reads 32'h11BB_33DD.
REQ-029 Write addr BASE+2, then read BASE+4*REG_NUMBER -> both done with error 1, read_data_o 0, storage unchanged.
REQ-030 READ_ONLY_MASK bit 0 set, write reg 0 with 32'hFFFF_FFFF -> error 1; read reg 0 returns RESET_VALUE.
REQ-031 Second write_request_i during WAIT -> ignored, exactly one done; simultaneous read/write reg 3 (old 5, new 9) completing same cycle -> read returns 5, later read returns 9.
REQ-032 rst_i asserted one cycle after write accept -> no done pulse, register unchanged, ready_o=1 after reset.
